// File: rtl/sync_pulse_train.sv
// Optical synchronizing pulse train generator: launches on a rising start level,
// emits PULSE_CNT pulses after DELAY_CYC, flags completion and aborts on start falling.
module sync_pulse_train #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DELAY_CYC = 100,
  parameter int unsigned PULSE_W   = 50,
  parameter int unsigned PERIOD    = 1000,
  parameter int unsigned PULSE_CNT = 10
) (
  input  logic        pg_clk,
  input  logic        pg_rst,
  input  logic        pg_start,
  output logic        pg_o,
  output logic        end_flg,
  output logic        pg_busy,
  output logic        pg_abort,
  output logic [15:0] pg_num
);

  localparam int unsigned NUM_W = 16;

  // Terminal counts: the counter restarts at zero on every state entry.
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(PERIOD - PULSE_W - 1);
  localparam logic [NUM_W-1:0] NUM_LAST  = NUM_W'(PULSE_CNT - 1);

  localparam longint unsigned CNT_MAX =
    (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_W) - 64'd1);

  if (CNT_W == 0 || CNT_W > 64 ||
      64'(DELAY_CYC) > CNT_MAX || 64'(PULSE_W) > CNT_MAX || 64'(PERIOD) > CNT_MAX ||
      PULSE_W == 0 || PERIOD <= PULSE_W ||
      PULSE_CNT == 0 || PULSE_CNT > 65535) begin : g_bad_params
    $error("sync_pulse_train: parameter set out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             start_q;
  logic             active;

  assign active = (state == S_DELAY) || (state == S_HIGH) || (state == S_LOW);

  always_ff @(posedge pg_clk) begin
    if (pg_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      start_q  <= 1'b0;
      pg_o     <= 1'b0;
      end_flg  <= 1'b0;
      pg_busy  <= 1'b0;
      pg_abort <= 1'b0;
      pg_num   <= '0;
    end else begin
      start_q <= pg_start;
      cnt     <= cnt + CNT_W'(1);
      // Start dropping while the train runs wins over any phase transition.
      if (active && !pg_start) begin
        state    <= S_IDLE;
        cnt      <= '0;
        pg_o     <= 1'b0;
        pg_busy  <= 1'b0;
        pg_abort <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            cnt <= '0;
            if (pg_start && !start_q) begin
              pg_num   <= '0;
              pg_abort <= 1'b0;
              pg_busy  <= 1'b1;
              if (DELAY_CYC == 0) begin
                state <= S_HIGH;
                pg_o  <= 1'b1;
              end else begin
                state <= S_DELAY;
              end
            end
          end
          S_DELAY: begin
            if (cnt == DLY_LAST) begin
              state <= S_HIGH;
              cnt   <= '0;
              pg_o  <= 1'b1;
            end
          end
          S_HIGH: begin
            if (cnt == HIGH_LAST) begin
              cnt    <= '0;
              pg_o   <= 1'b0;
              pg_num <= pg_num + NUM_W'(1);
              if (pg_num == NUM_LAST) begin
                state   <= S_DONE;
                pg_busy <= 1'b0;
                end_flg <= 1'b1;
              end else begin
                state <= S_LOW;
              end
            end
          end
          S_LOW: begin
            if (cnt == LOW_LAST) begin
              state <= S_HIGH;
              cnt   <= '0;
              pg_o  <= 1'b1;
            end
          end
          S_DONE: begin
            cnt <= '0;
            if (!pg_start) begin
              state   <= S_IDLE;
              end_flg <= 1'b0;
            end
          end
          default: begin
            state   <= S_IDLE;
            cnt     <= '0;
            pg_o    <= 1'b0;
            pg_busy <= 1'b0;
            end_flg <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
